pacman_soc_keycode_in: RTL and testbench
========================================

PACMAN_SOC_KEYCODE_IN -- requirements
Module: pacman_soc_keycode_in

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the in_port and data path width (1..32).
REQ-002 The block SHALL have parameter EDGE_TYPE, default 0, meaning the captured edge: 0 rising, 1 falling, 2 any.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port address, input, 2, the Avalon-MM slave word address.
REQ-006 The block SHALL have port chipselect, input, 1, the slave select.
REQ-007 The block SHALL have port write_n, input, 1, an active-low write strobe, qualified by chipselect.
REQ-008 The block SHALL have port writedata, input, 32, the write data.
REQ-009 The block SHALL have port readdata, output, 32, the registered read data.
REQ-010 The block SHALL have port in_port, input, WIDTH, asynchronous external data such as the keycode from the USB/keyboard side.
REQ-011 The block SHALL have port irq, output, 1, a level interrupt request.

Function
REQ-012 in_port SHALL pass through a two-flop synchronizer; sync_q is the second stage.
REQ-013 A prev_q register SHALL hold sync_q delayed one cycle; edge bits SHALL be sync_q&~prev_q (EDGE_TYPE 0), ~sync_q&prev_q (1), or sync_q^prev_q (2).
REQ-014 Address map: 0 is data (sync_q, read-only); 1 reads 0; 2 is irqmask (RW, WIDTH bits); 3 is edge_capture (read, write-1-to-clear).
REQ-015 readdata SHALL update every cycle from the current address, giving read latency 1; unused upper bits SHALL read 0.
REQ-016 A write SHALL occur when chipselect=1 and write_n=0; writes to addresses 0 and 1 SHALL be ignored.
REQ-017 An edge_capture bit SHALL set on a detected edge and clear on a write of 1 to that bit at address 3; if the set and clear coincide, set SHALL win.
REQ-018 irq SHALL be the combinational OR-reduction of (edge_capture & irqmask).
REQ-019 A 2-bit warm-up counter SHALL suppress edge detection until 3 cycles after reset deasserts, so pipeline fill causes no spurious edges.
REQ-020 A change on in_port SHALL appear in edge_capture exactly 3 clk edges after it is sampled by the first synchronizer flop.

Reset
REQ-021 When reset=1 at a clk edge, the synchronizer, prev_q, irqmask, edge_capture, readdata and the warm-up counter SHALL all clear to 0, so irq is 0.
REQ-022 Reset asserted mid-operation SHALL discard pending captures and restart warm-up.

Configuration
REQ-023 With macro PACMAN_SOC_KEYCODE_IN_EDGE_CAPTURE_EN defined, REQ-013/017/018/019 logic SHALL be present.
REQ-024 Without PACMAN_SOC_KEYCODE_IN_EDGE_CAPTURE_EN, addresses 2 and 3 SHALL read 0, writes to them SHALL be ignored, irq SHALL be tied to 0, and no edge or mask registers SHALL exist.

Structure
REQ-025 Package pacman_soc_pio_pkg SHALL hold the address constants ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3 and the EDGE_TYPE encodings.
REQ-026 The synchronizer SHALL be the sub-module pacman_soc_sync2 (parameterized width, synchronous active-high reset).

Verification
REQ-027 Reset is released; in_port=32'hFFFF_FFFF is held from reset; after warm-up, read address 3 -> readdata=0 and irq=0.
REQ-028 in_port=32'h0000_0041 is applied and address 0 is read 4 cycles later -> readdata=32'h0000_0041.
REQ-029 irqmask=32'h1 is written, then in_port bit0 rises (EDGE_TYPE 0) -> edge_capture=32'h1 and irq=1 on the 3rd clk edge after sampling.
REQ-030 32'h1 is written to address 3 in the same cycle a new bit0 edge is detected -> edge_capture bit0 stays 1 and irq stays 1.
REQ-031 32'h1 is written to address 3 with no new edge -> edge_capture=0 and irq=0 the next cycle; a write to address 0 leaves the data read unchanged.
REQ-032 With the macro undefined, 32'hFFFF_FFFF is written to addresses 2 and 3 -> both read 0 and irq remains 0 under input toggling.

Source files
------------

// File: rtl/pacman_soc_pio_pkg.sv
// Shared register map and edge-type encodings for the PIO-style keycode input port.
package pacman_soc_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pacman_soc_sync2.sv
// Two-flop synchronizer for a WIDTH-bit bus with synchronous active-high reset.
module pacman_soc_sync2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/pacman_soc_keycode_in.sv
// Avalon-MM keycode input port: synchronized data read, optional edge capture + IRQ.
// Edge capture, irqmask and irq exist only when PACMAN_SOC_KEYCODE_IN_EDGE_CAPTURE_EN is defined.
module pacman_soc_keycode_in
  import pacman_soc_pio_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int EDGE_TYPE = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync_q;
  logic [31:0]      rd_mux;

  pacman_soc_sync2 #(.WIDTH(WIDTH)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_port),
    .q     (sync_q)
  );

`ifdef PACMAN_SOC_KEYCODE_IN_EDGE_CAPTURE_EN
  logic             wr_en;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_bits;
  logic [WIDTH-1:0] clr_bits;
  logic [1:0]       warm_cnt;
  logic             warm_done;
  logic             unused_wr;

  assign wr_en     = chipselect & ~write_n;
  assign warm_done = (warm_cnt == 2'd3);
  assign unused_wr = ^writedata;

  // Edges are masked until the synchronizer and prev_q hold real samples.
  always_comb begin
    edge_bits = '0;
    if (warm_done) begin
      case (EDGE_TYPE)
        EDGE_FALLING: edge_bits = ~sync_q & prev_q;
        EDGE_ANY:     edge_bits = sync_q ^ prev_q;
        default:      edge_bits = sync_q & ~prev_q;
      endcase
    end
    clr_bits = '0;
    if (wr_en && address == ADDR_EDGECAP) clr_bits = writedata[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q       <= '0;
      irqmask      <= '0;
      edge_capture <= '0;
      warm_cnt     <= '0;
    end else begin
      prev_q <= sync_q;
      if (!warm_done) warm_cnt <= warm_cnt + 2'd1;
      if (wr_en && address == ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
      // A new edge in the same cycle as a clear keeps the bit set.
      edge_capture <= (edge_capture & ~clr_bits) | edge_bits;
    end
  end

  assign irq = |(edge_capture & irqmask);

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = sync_q;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_capture;
      default:      rd_mux = '0;
    endcase
  end
`else
  logic unused_wr;

  assign unused_wr = ^{writedata, chipselect, write_n};
  assign irq       = 1'b0;

  always_comb begin
    rd_mux = '0;
    if (address == ADDR_DATA) rd_mux[WIDTH-1:0] = sync_q;
  end
`endif

  // Registered read: one cycle of latency from address to readdata.
  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_mux;
  end

endmodule

// File: tb/tb_pacman_soc_keycode_in.sv
// Directed, table-driven bench for pacman_soc_keycode_in (default or edge-capture build).
module tb_pacman_soc_keycode_in;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] in_port;
  logic        irq;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [31:0] in_val;
    logic [1:0]  addr;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [6];

  pacman_soc_keycode_in #(.WIDTH(32), .EDGE_TYPE(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    cyc(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input string name, input logic [31:0] exp);
    address = a;
    cyc(1);
    check(name, readdata, exp);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0041, 2'd0, 32'h0000_0041, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 2'd0, 32'hFFFF_FFFF, 1'b0};
    vecs[2] = '{32'h0000_0000, 2'd0, 32'h0000_0000, 1'b0};
    vecs[3] = '{32'hA5A5_5A5A, 2'd0, 32'hA5A5_5A5A, 1'b0};
    vecs[4] = '{32'h1234_5678, 2'd1, 32'h0000_0000, 1'b0};
    vecs[5] = '{32'h8000_0001, 2'd0, 32'h8000_0001, 1'b0};

    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 32'h0;
    cyc(3);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;
    cyc(4);

    for (int i = 0; i < 6; i++) begin
      in_port = vecs[i].in_val;
      address = vecs[i].addr;
      cyc(4);
      check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vecs[i].exp_irq});
    end

    // Read latency: new data visible on readdata after the 3rd edge.
    in_port = 32'h0000_0055;
    address = 2'd0;
    cyc(2);
    check("latency_old", readdata, 32'h8000_0001);
    cyc(1);
    check("latency_new", readdata, 32'h0000_0055);

`ifdef PACMAN_SOC_KEYCODE_IN_EDGE_CAPTURE_EN
    in_port = 32'hFFFF_FFFF;
    reset   = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(4);
    rd(2'd3, "warmup_edgecap", 32'h0);
    check("warmup_irq", {31'h0, irq}, 32'h0);

    wr(2'd2, 32'h1);
    rd(2'd2, "irqmask_rb", 32'h1);

    in_port = 32'hFFFF_FFFE;
    cyc(5);
    rd(2'd3, "fall_ignored", 32'h0);

    in_port = 32'hFFFF_FFFF;
    cyc(2);
    check("irq_edge2", {31'h0, irq}, 32'h0);
    cyc(1);
    check("irq_edge3", {31'h0, irq}, 32'h1);
    rd(2'd3, "edgecap_set", 32'h1);

    // Clear lands on the same edge that detects a new bit0 rise.
    in_port = 32'hFFFF_FFFE;
    cyc(5);
    in_port = 32'hFFFF_FFFF;
    cyc(2);
    address    = 2'd3;
    writedata  = 32'h1;
    chipselect = 1'b1;
    write_n    = 1'b0;
    cyc(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    check("setwins_irq", {31'h0, irq}, 32'h1);
    rd(2'd3, "setwins_edgecap", 32'h1);

    wr(2'd3, 32'h1);
    check("clear_irq", {31'h0, irq}, 32'h0);
    rd(2'd3, "clear_edgecap", 32'h0);
    wr(2'd0, 32'h1234_5678);
    rd(2'd0, "data_wr_ignored", 32'hFFFF_FFFF);

    in_port = 32'hFFFF_FFDF;
    cyc(5);
    in_port = 32'hFFFF_FFFF;
    cyc(4);
    rd(2'd3, "unmasked_edgecap", 32'h0000_0020);
    check("unmasked_irq", {31'h0, irq}, 32'h0);

    reset = 1'b1;
    cyc(1);
    check("midreset_rd", readdata, 32'h0);
    check("midreset_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;
    cyc(4);
    rd(2'd3, "midreset_edgecap", 32'h0);
    rd(2'd2, "midreset_mask", 32'h0);
`else
    wr(2'd2, 32'hFFFF_FFFF);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd2, "nocap_addr2", 32'h0);
    rd(2'd3, "nocap_addr3", 32'h0);
    for (int i = 0; i < 4; i++) begin
      in_port = ~in_port;
      cyc(4);
      check($sformatf("nocap_irq%0d", i), {31'h0, irq}, 32'h0);
    end
    rd(2'd0, "nocap_data", 32'h0000_0055);
    wr(2'd0, 32'hDEAD_BEEF);
    rd(2'd0, "data_wr_ignored", 32'h0000_0055);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
